// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared state encoding and default width for the bit-serial
//                arithmetic family (subtractor now, adder later).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Operand/result bundle with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, b_in,
        input  d, b_out, busy, done
    );

    modport slave (
        input  start, a, b, b_in,
        output d, b_out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : 1-bit combinational subtract cell, x - y - r_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic x,
    input  wire logic y,
    input  wire logic r_in,
    output logic      diff,
    output logic      r_out
);

    logic w_xy;

    assign w_xy  = x ^ y;
    assign diff  = w_xy ^ r_in;
    assign r_out = (~x & y) | (~w_xy & r_in);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial D = A - B - b_in, LSB first, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = $clog2(WIDTH) + 1
)(
    input  wire logic          clk,
    input  wire logic          reset,
    serial_subtractor_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_b_out;
    logic             w_diff;
    logic             w_borrow_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_cell (
        .x     (r_sa[0]),
        .y     (r_sb[0]),
        .r_in  (r_borrow),
        .diff  (w_diff),
        .r_out (w_borrow_next)
    );

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:                 w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Result registers load on the SHIFT->DONE edge so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_d      <= '0;
            r_b_out  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa     <= bus.a;
                        r_sb     <= bus.b;
                        r_borrow <= bus.b_in;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_borrow_next;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_d     <= w_res_next;
                        r_b_out <= w_borrow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.d     = r_d;
    assign bus.b_out = r_b_out;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       b_in;
        logic [7:0] exp_d;
        logic       exp_bout;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Full operation with timing checks; operands are scrambled after the start edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbi,
                         input logic [7:0] prev_d, input logic prev_b,
                         input logic [7:0] exp_d, input logic exp_b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.b_in  = tbi;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.b_in  = ~tbi;
        for (int k = 0; k < WIDTH; k++) begin
            chk("shift_busy", 16'(bus.busy), 16'd1);
            chk("shift_no_done", 16'(bus.done), 16'd0);
            chk("shift_d_hold", {7'd0, bus.b_out, bus.d}, {7'd0, prev_b, prev_d});
            @(negedge clk);
        end
        chk("done_pulse", 16'(bus.done), 16'd1);
        chk("done_busy", 16'(bus.busy), 16'd1);
        chk("result_d", 16'(bus.d), 16'(exp_d));
        chk("result_b_out", 16'(bus.b_out), 16'(exp_b));
        @(negedge clk);
        chk("after_done_low", 16'(bus.done), 16'd0);
        chk("after_busy_low", 16'(bus.busy), 16'd0);
        chk("after_d_stable", {7'd0, bus.b_out, bus.d}, {7'd0, exp_b, exp_d});
    endtask

    vec_t       vecs [11];
    logic [7:0] prev_d;
    logic       prev_b;
    logic [29:0] done_seen;
    logic [29:0] busy_seen;
    int          pulses;
    int          stray;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{8'h09, 8'h01, 1'b0, 8'h08, 1'b0};
        vecs[1]  = '{8'h40, 8'h04, 1'b0, 8'h3C, 1'b0};
        vecs[2]  = '{8'h94, 8'h89, 1'b0, 8'h0B, 1'b0};
        vecs[3]  = '{8'h11, 8'h11, 1'b1, 8'hFF, 1'b1};
        vecs[4]  = '{8'h23, 8'h29, 1'b0, 8'hFA, 1'b1};
        vecs[5]  = '{8'hE2, 8'hE1, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[7]  = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[8]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[10] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_d", 16'(bus.d), 16'd0);
        chk("reset_b_out", 16'(bus.b_out), 16'd0);
        chk("reset_busy", 16'(bus.busy), 16'd0);
        chk("reset_done", 16'(bus.done), 16'd0);

        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        chk("idle_no_activity", 16'(stray), 16'd0);

        prev_d = 8'h00;
        prev_b = 1'b0;
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].b_in, prev_d, prev_b,
                  vecs[i].exp_d, vecs[i].exp_bout);
            prev_d = vecs[i].exp_d;
            prev_b = vecs[i].exp_bout;
        end

        // start held high: done at 8, 18, 28 after the first accepting edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h40;
        bus.b     = 8'h04;
        bus.b_in  = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            done_seen[i] = bus.done;
            busy_seen[i] = bus.busy;
        end
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) if (done_seen[i]) pulses++;
        chk("b2b_pulse_count", 16'(pulses), 16'd3);
        chk("b2b_done_8", 16'(done_seen[8]), 16'd1);
        chk("b2b_done_18", 16'(done_seen[18]), 16'd1);
        chk("b2b_done_28", 16'(done_seen[28]), 16'd1);
        chk("b2b_idle_gap", 16'(busy_seen[9]), 16'd0);
        chk("b2b_restart", 16'(busy_seen[10]), 16'd1);
        chk("b2b_result", {7'd0, bus.b_out, bus.d}, {7'd0, 1'b0, 8'h3C});
        @(negedge clk);
        chk("b2b_stops", 16'(bus.busy), 16'd0);

        // Reset during the 4th SHIFT cycle.
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h01;
        bus.b_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_done", 16'(bus.done), 16'd0);
        chk("abort_d", {7'd0, bus.b_out, bus.d}, 16'd0);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        chk("abort_no_done", 16'(stray), 16'd0);
        do_op(8'h05, 8'h07, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Sequential bit-serial subtractor. Computes D = A − B − b_in, one bit per clock, LSB first.
- It is the inverse-direction companion to the team's combinational ripple carry adder.
- Shares the 8-bit operand/borrow port style with the adder, so both can be driven from the same Basys3 switch/LED top level and cross-checked against each other.
- Start/busy/done handshake; the result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are ≥ 2.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in, subtracted together with b.
- d  output  WIDTH  difference, registered.
- b_out  output  1  borrow-out; 1 when A < B + b_in.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when d/b_out update.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - state=IDLE.
  - d=0, b_out=0, busy=0, done=0.
  - Working registers and counter cleared.
- Reset takes priority over every other input, including mid-operation. An aborted operation produces no done pulse, and d is cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - If start=1, capture a→sa, b→sb, b_in→borrow, counter=0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - busy=1. Each cycle processes one bit with x=sa[0], y=sb[0], r=borrow:
    - diff = x ^ y ^ r
    - borrow_next = (~x & y) | (~(x ^ y) & r)
  - Right-shift sa and sb by 1.
  - Shift diff into the MSB of the working result register.
  - counter++.
  - When counter reaches WIDTH−1 (the last bit is processed in this cycle), go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - d ← working result and b_out ← final borrow, registered on entry, so they are valid when done=1.
  - done=1, busy=1, then go to IDLE.
- Latency:
  - start is sampled at edge N.
  - done=1 during the cycle after edge N+WIDTH, i.e. done is high after edge N+WIDTH.
  - A new start is accepted at the earliest in the cycle after done.
  - Throughput: one result per WIDTH+2 cycles.
- d/b_out hold their previous value throughout SHIFT. They change only on DONE entry or reset.
- start while busy or in DONE is ignored; it is not queued.
- a, b, b_in may change freely after the start edge; only the captured values are used.
- Width rules:
  - The result is modulo 2^WIDTH.
  - b_out is the true borrow: {b_out,d} = A − B − b_in in (WIDTH+1)-bit two's complement.
  - Wrap examples: 0x00−0x01 → d=0xFF, b_out=1. A=B with b_in=1 → d=0xFF, b_out=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package serial_arith_pkg:
  - State encoding constants: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - Default WIDTH.
  - The same package is reused by a planned serial adder.
- One sub-module, full_subtractor: 1-bit x, y, r_in → diff, r_out. Purely combinational; it is the mirror of the adder's full-adder cell.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- Reset then idle: reset high for 2 cycles → d=0x00, b_out=0, busy=0, done=0; no done pulse while start=0.
- Basic subtractions (each awaits done, WIDTH=8):
  - a=0x09, b=0x01, b_in=0 → d=0x08, b_out=0.
  - a=0x40, b=0x04 → d=0x3C, b_out=0.
  - a=0x94, b=0x89 → d=0x0B, b_out=0.
- Borrow and wrap cases:
  - a=0x11, b=0x11, b_in=1 → d=0xFF, b_out=1.
  - a=0x23, b=0x29, b_in=0 → d=0xFA, b_out=1.
  - a=0xE2, b=0xE1, b_in=1 → d=0x00, b_out=0.
- Timing:
  - start sampled at edge N → done high exactly after edge N+8, for one cycle.
  - busy high for cycles N+1..N+8.
  - d unchanged from the prior result until done.
  - Changing a/b after the start edge does not alter the result.
- start held high continuously: operations repeat back-to-back with one IDLE cycle between done and the next busy. Extra start pulses during SHIFT are ignored, giving one result per start acceptance.
- Reset mid-operation: assert reset at the 4th SHIFT cycle → next cycle state IDLE, d=0, busy=0, no done. A following start with a=0x05, b=0x07 → d=0xFE, b_out=1.
